// File: rtl/multi_operand_add_seq.sv
// Multi-operand add sequencer: folds a valid/ready operand stream into cin + sum,
// consuming operands in pairs through one 3-operand add (acc + a + b) per pair.
module multi_operand_add_seq #(
  parameter int WIDTH   = 4,
  parameter int MAX_OPS = 8,
  parameter int CNT_W   = 4,
  parameter int ACC_W   = WIDTH + 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic             cin,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] op_data,
  output logic             op_ready,
  output logic             res_valid,
  output logic [ACC_W-1:0] res_data,
  input  logic             res_ready,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, COLL_A, COLL_B, TAIL, DONE} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [WIDTH-1:0] a_reg;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] n_sat;
  logic             op_fire;
  logic             res_fire;
  logic             last_op;

  assign n_sat    = (num_ops > CNT_W'(MAX_OPS)) ? CNT_W'(MAX_OPS) : num_ops;
  assign op_fire  = op_valid && op_ready;
  assign res_fire = res_valid && res_ready;
  assign last_op  = (remaining == CNT_W'(1));
  assign res_data = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (n_sat == '0) ? DONE : COLL_A;
      COLL_A:  if (op_fire) state_nxt = last_op ? TAIL : COLL_B;
      COLL_B:  if (op_fire) state_nxt = last_op ? DONE : COLL_A;
      TAIL:    state_nxt = DONE;
      DONE:    if (res_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    op_ready  = (state == COLL_A) || (state == COLL_B);
    res_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Odd counts park the last operand in a_reg; TAIL folds it in with a zero third term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      a_reg     <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc       <= ACC_W'(cin);
          remaining <= n_sat;
        end
        COLL_A: if (op_fire) begin
          a_reg     <= op_data;
          remaining <= remaining - CNT_W'(1);
        end
        COLL_B: if (op_fire) begin
          acc       <= acc + ACC_W'(a_reg) + ACC_W'(op_data);
          remaining <= remaining - CNT_W'(1);
        end
        TAIL:    acc <= acc + ACC_W'(a_reg);
        default: ;
      endcase
    end
  end

endmodule
